// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared encodings for the data-memory access controller: pipeline load and
// store type codes, the controller FSM states, and an alignment helper.
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

  // Load type as presented by the MEM stage.
  typedef enum logic [2:0] {
    LOAD_LB   = 3'b000,
    LOAD_LH   = 3'b001,
    LOAD_LW   = 3'b010,
    LOAD_LBU  = 3'b100,
    LOAD_LHU  = 3'b101,
    LOAD_NONE = 3'b111
  } load_type_e;

  // Store type as presented by the MEM stage.
  typedef enum logic [1:0] {
    STORE_NONE = 2'b00,
    STORE_SB   = 2'b01,
    STORE_SH   = 2'b10,
    STORE_SW   = 2'b11
  } store_type_e;

  // Controller FSM.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Access size codes used by the alignment check.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Width of the optional access timeout counter.
  localparam int TIMER_W = 8;

  // Halfwords need addr[0]=0, words need addr[1:0]=00, bytes are always fine.
  function automatic logic is_aligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: return ~addr_lo[0];
      SIZE_WORD: return (addr_lo == 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load formatter: picks the byte or halfword lane addressed by
// addr_lo out of the read word and sign- or zero-extends it to 32 bits.
//
// Ports
//   rdata     in  32  raw word returned by the memory
//   addr_lo   in   2  low byte-address bits of the access
//   load_type in   3  load encoding (see mem_access_ctrl_pkg::load_type_e)
//   data      out 32  extended load result
// -----------------------------------------------------------------------------
module load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    data     = rdata;
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: data = {24'h0, byte_sel};
      LOAD_LH:  data = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: data = {16'h0, half_sel};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage data-memory access controller. Accepts one aligned load or store
// from the pipeline, stalls the pipeline while the memory handshake is in
// flight, formats store lanes / byte enables and extends load data.
//
// Optional feature: define DMEM_TIMEOUT_EN to abort an access that has not
// seen dmem_ready after TIMEOUT_CYCLES access cycles (reported as bus_err).
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   mem_result            in  byte address
//   mem_op2_selected      in  store data
//   mem_memory_write      in  store enable
//   mem_memory_load_type  in  load encoding (111 = no load)
//   mem_memory_store_type in  store encoding (00 = no store)
//   dmem_req/we/addr/wdata/be  out  memory request, held stable while pending
//   dmem_ready/rdata/err  in  memory completion, read word, bus error
//   mem_stall             out freeze upstream pipeline registers
//   mem_load_data         out extended load result (holds outside DONE)
//   mem_load_valid        out load result valid (DONE cycle of a load)
//   misalign_err          out one-cycle pulse after a rejected misaligned op
//   bus_err               out one-cycle pulse in DONE of a failed access
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_op2_selected,
  input  logic        mem_memory_write,
  input  logic [2:0]  mem_memory_load_type,
  input  logic [1:0]  mem_memory_store_type,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        mem_stall,
  output logic [31:0] mem_load_data,
  output logic        mem_load_valid,
  output logic        misalign_err,
  output logic        bus_err
);

  state_e      state_q, state_d;
  logic        is_store, is_load, op_valid, aligned;
  logic        accept, misalign;
  logic [1:0]  op_size;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        is_load_q, err_q;
  logic [2:0]  ld_type_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] ext_data;
  logic        timeout_hit;
  logic        finish;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  always_comb begin
    is_store = mem_memory_write && (mem_memory_store_type != STORE_NONE);
    is_load  = (mem_memory_load_type != LOAD_NONE);
    op_valid = is_store || is_load;
    op_size  = SIZE_WORD;
    if (is_store) begin
      case (mem_memory_store_type)
        STORE_SB: op_size = SIZE_BYTE;
        STORE_SH: op_size = SIZE_HALF;
        default:  op_size = SIZE_WORD;
      endcase
    end else begin
      case (mem_memory_load_type)
        LOAD_LB, LOAD_LBU: op_size = SIZE_BYTE;
        LOAD_LH, LOAD_LHU: op_size = SIZE_HALF;
        default:           op_size = SIZE_WORD;
      endcase
    end
    aligned  = is_aligned(op_size, mem_result[1:0]);
    accept   = (state_q == ST_IDLE) && op_valid && aligned;
    misalign = (state_q == ST_IDLE) && op_valid && !aligned;
  end

  // Store lane formatting; loads always fetch the whole word.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = '0;
    if (is_store) begin
      case (op_size)
        SIZE_BYTE: begin
          be_d    = 4'b0001 << mem_result[1:0];
          wdata_d = {4{mem_op2_selected[7:0]}};
        end
        SIZE_HALF: begin
          be_d    = 4'b0011 << mem_result[1:0];
          wdata_d = {2{mem_op2_selected[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = mem_op2_selected;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional access timeout
  // ---------------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0] tmo_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (accept) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_ACCESS) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // The counter value equals the number of ACCESS cycles already spent.
  assign timeout_hit = (state_q == ST_ACCESS) && !dmem_ready &&
                       (tmo_cnt_q == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign finish = (state_q == ST_ACCESS) && (dmem_ready || timeout_hit);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: if (finish) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dmem_req       = (state_q == ST_ACCESS);
    // NOTE: the accept term comes straight from pipeline inputs, so it is
    // qualified with rst_n to keep mem_stall low while reset is asserted.
    mem_stall      = (state_q == ST_ACCESS) || (accept && rst_n);
    mem_load_valid = (state_q == ST_DONE) && is_load_q;
    bus_err        = (state_q == ST_DONE) && err_q;
  end

  // ---------------------------------------------------------------------------
  // Request / response registers
  // ---------------------------------------------------------------------------
  load_extend u_load_extend (
    .rdata     (dmem_rdata),
    .addr_lo   (addr_lo_q),
    .load_type (ld_type_q),
    .data      (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_be       <= '0;
      dmem_we       <= 1'b0;
      is_load_q     <= 1'b0;
      ld_type_q     <= LOAD_NONE;
      addr_lo_q     <= '0;
      err_q         <= 1'b0;
      mem_load_data <= '0;
      misalign_err  <= 1'b0;
    end else begin
      misalign_err <= misalign;
      if (accept) begin
        dmem_addr  <= {mem_result[31:2], 2'b00};
        dmem_wdata <= wdata_d;
        dmem_be    <= be_d;
        dmem_we    <= is_store;
        is_load_q  <= !is_store;
        ld_type_q  <= mem_memory_load_type;
        addr_lo_q  <= mem_result[1:0];
      end
      if (finish) begin
        // A timeout is reported exactly like a bus error.
        err_q <= dmem_ready ? dmem_err : 1'b1;
        if (is_load_q) begin
          mem_load_data <= (dmem_ready && !dmem_err) ? ext_data : '0;
        end
      end
    end
  end

endmodule
